// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM row read controller.
// Holds the default BRAM geometry, the row organisation (16 words per row),
// the address slicing constants for row tag / word index, and the
// controller state encoding.
package bram_rd_pkg;

    localparam int ADDR_W_DEF    = 13;
    localparam int DATA_W_DEF    = 32;
    localparam int WORDS_PER_ROW = 16;

    // word index = addr[IDX_W-1:0], row tag = addr[ADDR_W-1:TAG_LSB]
    localparam int IDX_W   = 4;
    localparam int TAG_LSB = IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RESP,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/bram_rd_delay_line.sv
// Read-return alignment pipe.
// RD_LATENCY-deep shift register carrying a valid bit plus the word slot of
// each issued BRAM read, so that ret_valid/ret_slot line up with the cycle in
// which the BRAM presents the corresponding data.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset (clears pipe)
//   issue_valid/slot       read enable and slot as presented to the BRAM
//   ret_valid/slot         same, delayed RD_LATENCY cycles
module bram_rd_delay_line
    import bram_rd_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_slot,
    output logic             ret_valid,
    output logic [IDX_W-1:0] ret_slot
);

    logic [RD_LATENCY-1:0] vld_sr;
    logic [IDX_W-1:0]      slot_sr [RD_LATENCY];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_sr <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                slot_sr[i] <= '0;
            end
        end else begin
            vld_sr[0]  <= issue_valid;
            slot_sr[0] <= issue_slot;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                slot_sr[i] <= slot_sr[i-1];
            end
        end
    end

    assign ret_valid = vld_sr[RD_LATENCY-1];
    assign ret_slot  = slot_sr[RD_LATENCY-1];

endmodule

// File: rtl/bram_row_rd_ctrl.sv
// BRAM row read controller.
// Serves a level-held word read request from a raw BRAM read port.
// With macro ROW_CACHE_EN defined, a miss fetches the whole 16-word row into
// a local buffer and later reads of the same row are answered without BRAM
// access; i_flush invalidates the buffer. Without ROW_CACHE_EN, every request
// issues exactly one BRAM read and i_flush is ignored.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_rd_trig, i_rd_addr  request (held until o_rd_done), word address
//   o_rd_data, o_rd_done  response data, one-cycle completion pulse
//   i_flush               row buffer invalidate
//   o_bram_en/addr        BRAM read enable / address
//   i_bram_dout           BRAM data, RD_LATENCY cycles after o_bram_en
module bram_row_rd_ctrl
    import bram_rd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_trig,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_done,
    input  logic              i_flush,
    output logic              o_bram_en,
    output logic [ADDR_W-1:0] o_bram_addr,
    input  logic [DATA_W-1:0] i_bram_dout
);

    state_t state, state_nxt;

    logic             accept;
    logic             hit;
    logic             fill_last;
    logic             issue_last;
    logic             dl_valid;
    logic [IDX_W-1:0] dl_slot;

    bram_rd_delay_line #(
        .RD_LATENCY(RD_LATENCY)
    ) u_delay_line (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .issue_valid(o_bram_en),
        .issue_slot (o_bram_addr[IDX_W-1:0]),
        .ret_valid  (dl_valid),
        .ret_slot   (dl_slot)
    );

    assign accept    = (state == ST_IDLE) && i_rd_trig;
    assign o_rd_done = (state == ST_RESP);

`ifdef ROW_CACHE_EN
    logic [DATA_W-1:0]         row_buf [WORDS_PER_ROW];
    logic [ADDR_W-1:TAG_LSB]   buf_tag;
    logic                      buf_valid;
    logic                      fill_flushed;
    logic [IDX_W-1:0]          req_idx;

    // A flush in the accept cycle must not be answered from stale data.
    assign hit        = buf_valid && !i_flush &&
                        (buf_tag == i_rd_addr[ADDR_W-1:TAG_LSB]);
    assign fill_last  = dl_valid && (dl_slot == IDX_W'(WORDS_PER_ROW - 1));
    assign issue_last = (o_bram_addr[IDX_W-1:0] == IDX_W'(WORDS_PER_ROW - 1));
`else
    logic unused_flush_slot;

    assign hit               = 1'b0;
    assign fill_last         = dl_valid;
    assign issue_last        = 1'b1;
    assign unused_flush_slot = ^{i_flush, dl_slot};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept)     state_nxt = hit ? ST_RESP : ST_FILL;
            ST_FILL:    if (fill_last)  state_nxt = ST_RESP;
            ST_RESP:                    state_nxt = ST_RELEASE;
            ST_RELEASE: if (!i_rd_trig) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // BRAM issue side: the enable is registered, so the first read appears in
    // the cycle after accept and the delay line sees exactly what the BRAM sees.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bram_en   <= 1'b0;
            o_bram_addr <= '0;
        end else if (accept && !hit) begin
            o_bram_en <= 1'b1;
`ifdef ROW_CACHE_EN
            o_bram_addr <= {i_rd_addr[ADDR_W-1:TAG_LSB], {IDX_W{1'b0}}};
`else
            o_bram_addr <= i_rd_addr;
`endif
        end else if (o_bram_en) begin
            if (issue_last) begin
                o_bram_en <= 1'b0;
            end else begin
                // stays inside the row: index < 15 here, so no carry into tag
                o_bram_addr <= o_bram_addr + ADDR_W'(1);
            end
        end
    end

`ifdef ROW_CACHE_EN
    // Buffer storage carries no reset; buf_valid alone qualifies it.
    always_ff @(posedge i_clk) begin
        if ((state == ST_FILL) && dl_valid) begin
            row_buf[dl_slot] <= i_bram_dout;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data    <= '0;
            buf_tag      <= '0;
            buf_valid    <= 1'b0;
            fill_flushed <= 1'b0;
            req_idx      <= '0;
        end else begin
            if (accept) begin
                req_idx <= i_rd_addr[IDX_W-1:0];
                if (hit) begin
                    o_rd_data <= row_buf[i_rd_addr[IDX_W-1:0]];
                end else begin
                    buf_tag      <= i_rd_addr[ADDR_W-1:TAG_LSB];
                    fill_flushed <= 1'b0;
                end
            end else if ((state == ST_FILL) && i_flush) begin
                fill_flushed <= 1'b1;
            end

            if ((state == ST_FILL) && dl_valid && (dl_slot == req_idx)) begin
                o_rd_data <= i_bram_dout;
            end

            // A flush seen anywhere during the fill keeps the buffer invalid
            // even though the requester still gets the freshly read word.
            if (i_flush || (accept && !hit)) begin
                buf_valid <= 1'b0;
            end else if ((state == ST_FILL) && fill_last) begin
                buf_valid <= !fill_flushed;
            end
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data <= '0;
        end else if ((state == ST_FILL) && dl_valid) begin
            o_rd_data <= i_bram_dout;
        end
    end
`endif

endmodule
